// File: rtl/burst_sram_responder.sv
// burst_sram_responder: AXI-style read-burst memory endpoint with a
// single-beat write channel. Reads return arlen+1 beats from an internal
// word array (FIXED / INCR / WRAP), writes update byte lanes in place.
module burst_sram_responder #(
    parameter int          DEPTH_DIG    = 12,
    parameter logic [31:0] BASE_ADDR    = 32'h8000_0000,
    parameter int          READ_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] araddr,
    input  logic        arvalid,
    output logic        arready,
    input  logic [7:0]  arlen,
    input  logic [1:0]  arburst,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rvalid,
    input  logic        rready,
    output logic        rlast,
    input  logic [31:0] awaddr,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wvalid,
    output logic        wready,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready
);

    typedef enum logic [1:0] {IDLE, LAT, RBEAT, WRESP} state_t;

    localparam int          WORDS        = 1 << DEPTH_DIG;
    localparam int          LAT_LAST_INT = (READ_LATENCY > 0) ? READ_LATENCY - 1 : 0;
    localparam logic [3:0]  LAT_LAST     = LAT_LAST_INT[3:0];

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [7:0]  len_q, len_d;
    logic [7:0]  beat_q, beat_d;
    logic [1:0]  burst_q, burst_d;
    logic        err_q, err_d;
    logic [3:0]  lat_q, lat_d;
    logic [1:0]  bresp_q, bresp_d;

    logic [31:0] mem [WORDS];

    logic        wrapLegal;
    logic        arErr;
    logic        memWrite;
    logic [31:0] wrapMask;
    logic [31:0] nextAddr;
    logic        beatInWindow;
    logic [31:0] beatWord;

    // A byte address maps to the array only if it sits at or above the base
    // and its word offset fits in DEPTH_DIG bits.
    function automatic logic inWindow(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE_ADDR;
        return (a >= BASE_ADDR) && ((off >> (DEPTH_DIG + 2)) == 32'd0);
    endfunction

    function automatic logic [DEPTH_DIG-1:0] wordIndex(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE_ADDR;
        return DEPTH_DIG'(off >> 2);
    endfunction

    // Classify the incoming request: reserved bursts and WRAP with a length
    // other than 2/4/8/16 still run, but as INCR with every beat flagged.
    always_comb begin
        wrapLegal = (arlen == 8'd1) || (arlen == 8'd3) || (arlen == 8'd7) || (arlen == 8'd15);
        arErr     = (arburst == 2'b11) || ((arburst == 2'b10) && !wrapLegal);
    end

    // Address of the following beat. For a legal WRAP, (len+1)*4-1 is simply
    // len with two ones appended, giving the wrap-window mask directly.
    always_comb begin
        wrapMask = {22'd0, len_q, 2'b11};
        nextAddr = addr_q + 32'd4;
        if (!err_q && (burst_q == 2'b00)) begin
            nextAddr = addr_q;
        end else if (!err_q && (burst_q == 2'b10)) begin
            nextAddr = (addr_q & ~wrapMask) | ((addr_q + 32'd4) & wrapMask);
        end
    end

    // Current beat lookup; the array is never written while a burst is being
    // returned, so the presented data stays stable through rready stalls.
    always_comb begin
        beatInWindow = inWindow(addr_q);
        beatWord     = mem[wordIndex(addr_q)];
    end

    // Next-state and handshake outputs; reads take priority over writes.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        len_d    = len_q;
        beat_d   = beat_q;
        burst_d  = burst_q;
        err_d    = err_q;
        lat_d    = lat_q;
        bresp_d  = bresp_q;
        arready  = 1'b0;
        awready  = 1'b0;
        wready   = 1'b0;
        rvalid   = 1'b0;
        rlast    = 1'b0;
        rdata    = 32'd0;
        rresp    = 2'b00;
        bvalid   = 1'b0;
        bresp    = 2'b00;
        memWrite = 1'b0;
        case (state_q)
            IDLE: begin
                arready = 1'b1;
                awready = !arvalid;
                wready  = !arvalid;
                if (arvalid) begin
                    addr_d  = araddr;
                    len_d   = arlen;
                    burst_d = arburst;
                    err_d   = arErr;
                    beat_d  = 8'd0;
                    lat_d   = 4'd0;
                    state_d = (READ_LATENCY > 0) ? LAT : RBEAT;
                end else if (awvalid && wvalid) begin
                    memWrite = inWindow(awaddr);
                    bresp_d  = inWindow(awaddr) ? 2'b00 : 2'b10;
                    state_d  = WRESP;
                end
            end
            LAT: begin
                if (lat_q == LAT_LAST) begin
                    state_d = RBEAT;
                end else begin
                    lat_d = lat_q + 4'd1;
                end
            end
            RBEAT: begin
                rvalid = 1'b1;
                rlast  = (beat_q == len_q);
                rdata  = beatInWindow ? beatWord : 32'd0;
                rresp  = (err_q || !beatInWindow) ? 2'b10 : 2'b00;
                if (rready) begin
                    if (beat_q == len_q) begin
                        state_d = IDLE;
                    end else begin
                        addr_d = nextAddr;
                        beat_d = beat_q + 8'd1;
                    end
                end
            end
            WRESP: begin
                bvalid = 1'b1;
                bresp  = bresp_q;
                if (bready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control registers; reset aborts any burst in flight.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            addr_q  <= 32'd0;
            len_q   <= 8'd0;
            beat_q  <= 8'd0;
            burst_q <= 2'b00;
            err_q   <= 1'b0;
            lat_q   <= 4'd0;
            bresp_q <= 2'b00;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            beat_q  <= beat_d;
            burst_q <= burst_d;
            err_q   <= err_d;
            lat_q   <= lat_d;
            bresp_q <= bresp_d;
        end
    end

    // Byte-lane write into the array; contents survive reset.
    always_ff @(posedge clk) begin
        if (rst && memWrite) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb[b]) begin
                    mem[wordIndex(awaddr)][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
    end

endmodule
